cpu_control_fsm: RTL

Multi-cycle control stage sitting directly upstream of the 8x8 register file and alongside the ALU. It accepts one 32-bit instruction per handshake and decodes it. It then sequences the register-file read (posedge-sampled, CTRL=1), operand capture, ALU execution and register-file write-back (negedge-sampled, CTRL=0). It owns every register-file control and address input, plus the write-data path back into it.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/cpu_operand_select.sv | 36 +++
 rtl/cpu_control_fsm.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle control stage:
// opcodes, ALU selects, FSM states and instruction field positions.
package cpu_pkg;

    localparam int OP_HI   = 31;
    localparam int OP_LO   = 24;
    localparam int DEST_HI = 18;
    localparam int DEST_LO = 16;
    localparam int SRC1_HI = 10;
    localparam int SRC1_LO = 8;
    localparam int SRC2_HI = 2;
    localparam int SRC2_LO = 0;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;

    localparam logic [2:0] ALU_FWD = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_RFREAD,
        S_EXEC,
        S_WB
    } state_t;

    // Only the fields still needed after the read addresses are issued.
    typedef struct packed {
        logic [7:0] op;
        logic [2:0] dest;
        logic [7:0] imm;
    } instr_t;

    function automatic logic op_legal(input logic [7:0] op);
        return op <= OP_OR;
    endfunction

endpackage

// File: rtl/cpu_operand_select.sv
// Picks ALU operand B (immediate, register, or negated register)
// and maps the opcode onto an ALU function select.
module cpu_operand_select
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [7:0]        op,
    input  logic [7:0]        imm,
    input  logic [DATA_W-1:0] rf_out2,
    output logic [DATA_W-1:0] operand_b,
    output logic [2:0]        alu_op
);

    always_comb begin
        operand_b = rf_out2;
        alu_op    = ALU_FWD;
        case (op)
            OP_LOADI: operand_b = DATA_W'(imm);
            OP_MOV:   alu_op = ALU_FWD;
            OP_ADD:   alu_op = ALU_ADD;
            OP_SUB: begin
                // subtract is done as an add of the two's complement
                alu_op    = ALU_ADD;
                operand_b = ~rf_out2 + DATA_W'(1);
            end
            OP_AND:   alu_op = ALU_AND;
            OP_OR:    alu_op = ALU_OR;
            default: begin
                operand_b = rf_out2;
                alu_op    = ALU_FWD;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control stage: decode, register read, execute and
// write-back sequencing for the 8x8 register file and ALU.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] OUT1addr,
    output logic [ADDR_W-1:0] OUT2addr,
    output logic [ADDR_W-1:0] INaddr,
    output logic              CTRL,
    input  logic [DATA_W-1:0] rf_out1,
    input  logic [DATA_W-1:0] rf_out2,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] IN,
    output logic              done,
    output logic              illegal
);

    state_t            state;
    instr_t            ir;
    logic              ctrl_q;
    logic [7:0]        new_op;
    logic [DATA_W-1:0] b_next;
    logic [2:0]        alu_next;
    logic              unused_bits;

    assign new_op      = instr[OP_HI:OP_LO];
    assign unused_bits = ^{instr[23:19], instr[15:11]};

    // Reset must block a write even mid-cycle, so it bypasses the flop.
    assign CTRL = ctrl_q | RESET;

    cpu_operand_select #(
        .DATA_W(DATA_W)
    ) u_sel (
        .op       (ir.op),
        .imm      (ir.imm),
        .rf_out2  (rf_out2),
        .operand_b(b_next),
        .alu_op   (alu_next)
    );

    always_ff @(posedge clk) begin
        if (RESET) begin
            state       <= S_IDLE;
            ir          <= '0;
            ctrl_q      <= 1'b1;
            instr_ready <= 1'b1;
            done        <= 1'b0;
            illegal     <= 1'b0;
            OUT1addr    <= '0;
            OUT2addr    <= '0;
            INaddr      <= '0;
            operand_a   <= '0;
            operand_b   <= '0;
            alu_op      <= ALU_FWD;
            IN          <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (instr_valid) begin
                        ir <= '{
                            op:   new_op,
                            dest: instr[DEST_HI:DEST_LO],
                            imm:  instr[IMM_HI:IMM_LO]
                        };
                        OUT1addr    <= ADDR_W'(instr[SRC1_HI:SRC1_LO]);
                        OUT2addr    <= ADDR_W'(instr[SRC2_HI:SRC2_LO]);
                        illegal     <= !op_legal(new_op);
                        instr_ready <= 1'b0;
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    illegal <= 1'b0;
                    if (!op_legal(ir.op)) begin
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end else if (ir.op == OP_LOADI) begin
                        alu_op    <= alu_next;
                        operand_a <= '0;
                        operand_b <= b_next;
                        state     <= S_EXEC;
                    end else begin
                        alu_op <= alu_next;
                        state  <= S_RFREAD;
                    end
                end
                S_RFREAD: begin
                    operand_a <= rf_out1;
                    operand_b <= b_next;
                    state     <= S_EXEC;
                end
                S_EXEC: begin
                    IN     <= alu_result;
                    INaddr <= ADDR_W'(ir.dest);
                    ctrl_q <= 1'b0;
                    state  <= S_WB;
                end
                S_WB: begin
                    ctrl_q      <= 1'b1;
                    done        <= 1'b1;
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
